// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator: command/response handshake in, one AXI-Lite
// read or write out, plus per-transaction latency and a saturating error-response count.
module axi_lite_master_port #(
   parameter int ADDR_W = 32,
   parameter int LAT_W  = 16,
   parameter int ERR_W  = 16
) (
   input  logic              pl_clk,
   input  logic              pl_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic [LAT_W-1:0]  rsp_latency,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [31:0]       m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [31:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_RSP} state_t;

   state_t state, state_nxt;

   logic [LAT_W-1:0]  lat_cnt, lat_cnt_d, lat_inc, rsp_latency_d;
   logic [ERR_W-1:0]  err_inc, err_count_d;
   logic [ADDR_W-1:0] awaddr_d, araddr_d;
   logic [31:0]       wdata_d, rsp_rdata_d;
   logic [3:0]        wstrb_d;
   logic [1:0]        rsp_resp_d;
   logic cmd_ready_d, rsp_valid_d, rsp_write_d;
   logic awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic accept, aw_ok, w_ok, b_hs, ar_hs, r_hs;

   // A channel is "ok" once its valid has been retired, so AW and W may finish in any order.
   assign accept  = cmd_valid & cmd_ready;
   assign aw_ok   = ~m_axi_awvalid | m_axi_awready;
   assign w_ok    = ~m_axi_wvalid  | m_axi_wready;
   assign b_hs    = m_axi_bvalid  & m_axi_bready;
   assign ar_hs   = m_axi_arvalid & m_axi_arready;
   assign r_hs    = m_axi_rvalid  & m_axi_rready;
   assign lat_inc = (&lat_cnt)   ? lat_cnt   : lat_cnt + LAT_W'(1);
   assign err_inc = (&err_count) ? err_count : err_count + ERR_W'(1);

   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         state         <= S_IDLE;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= '0;
         rsp_latency   <= '0;
         err_count     <= '0;
         lat_cnt       <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         state         <= state_nxt;
         cmd_ready     <= cmd_ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_write     <= rsp_write_d;
         rsp_rdata     <= rsp_rdata_d;
         rsp_resp      <= rsp_resp_d;
         rsp_latency   <= rsp_latency_d;
         err_count     <= err_count_d;
         lat_cnt       <= lat_cnt_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
         m_axi_araddr  <= araddr_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_rready  <= rready_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = cmd_write ? S_WR : S_RD;
         S_WR:      if (aw_ok && w_ok) state_nxt = S_WR_RESP;
         S_WR_RESP: if (b_hs) state_nxt = S_RSP;
         S_RD:      if (ar_hs) state_nxt = S_RD_DATA;
         S_RD_DATA: if (r_hs) state_nxt = S_RSP;
         S_RSP:     if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Next values of every registered output; nothing here reaches a port combinationally.
   always_comb begin
      cmd_ready_d   = cmd_ready;
      rsp_valid_d   = rsp_valid;
      rsp_write_d   = rsp_write;
      rsp_rdata_d   = rsp_rdata;
      rsp_resp_d    = rsp_resp;
      rsp_latency_d = rsp_latency;
      err_count_d   = err_count;
      awaddr_d      = m_axi_awaddr;
      awvalid_d     = m_axi_awvalid;
      wdata_d       = m_axi_wdata;
      wstrb_d       = m_axi_wstrb;
      wvalid_d      = m_axi_wvalid;
      bready_d      = m_axi_bready;
      araddr_d      = m_axi_araddr;
      arvalid_d     = m_axi_arvalid;
      rready_d      = m_axi_rready;
      lat_cnt_d     = (state == S_IDLE) ? lat_cnt : lat_inc;
      case (state)
         S_IDLE: if (accept) begin
            cmd_ready_d = 1'b0;
            lat_cnt_d   = '0;
            awaddr_d    = cmd_addr & ~ADDR_W'(3);
            araddr_d    = cmd_addr & ~ADDR_W'(3);
            wdata_d     = cmd_wdata;
            wstrb_d     = cmd_wstrb;
            rsp_write_d = cmd_write;
            awvalid_d   = cmd_write;
            wvalid_d    = cmd_write;
            arvalid_d   = ~cmd_write;
         end
         S_WR: begin
            awvalid_d = m_axi_awvalid & ~m_axi_awready;
            wvalid_d  = m_axi_wvalid  & ~m_axi_wready;
            if (aw_ok && w_ok) bready_d = 1'b1;
         end
         S_WR_RESP: if (b_hs) begin
            bready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = m_axi_bresp;
            rsp_latency_d = lat_inc;
            if (m_axi_bresp != 2'b00) err_count_d = err_inc;
         end
         S_RD: if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
         end
         S_RD_DATA: if (r_hs) begin
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = m_axi_rdata;
            rsp_resp_d    = m_axi_rresp;
            rsp_latency_d = lat_inc;
            if (m_axi_rresp != 2'b00) err_count_d = err_inc;
         end
         S_RSP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Bench for axi_lite_master_port: a cycle-level slave/host model drives directed and random
// transactions into two instances (default widths and LAT_W=4/ERR_W=2 for saturation).
module tb_axi_lite_master_port;
   localparam int ADDR_W = 32;

   logic pl_clk = 1'b0;
   logic pl_rst;
   logic cmd_valid, cmd_write, rsp_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [31:0] cmd_wdata, m_axi_rdata;
   logic [3:0]  cmd_wstrb;
   logic m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
   logic [1:0] m_axi_bresp, m_axi_rresp;

   logic cmd_ready, rsp_valid, rsp_write;
   logic [31:0] rsp_rdata, m_axi_wdata;
   logic [1:0]  rsp_resp;
   logic [15:0] rsp_latency, err_count;
   logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
   logic [3:0] m_axi_wstrb;
   logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;

   logic d2_cmd_ready, d2_rsp_valid, d2_rsp_write;
   logic [31:0] d2_rsp_rdata, d2_wdata;
   logic [1:0]  d2_rsp_resp;
   logic [3:0]  d2_rsp_latency, d2_wstrb;
   logic [1:0]  d2_err_count;
   logic [ADDR_W-1:0] d2_awaddr, d2_araddr;
   logic d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;

   int n_cmp = 0;
   int n_mis = 0;
   int err_model = 0;

   always #5 pl_clk = ~pl_clk;

   axi_lite_master_port #(.ADDR_W(ADDR_W)) dut (
      .pl_clk(pl_clk), .pl_rst(pl_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
      .err_count(err_count),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   axi_lite_master_port #(.ADDR_W(ADDR_W), .LAT_W(4), .ERR_W(2)) dut2 (
      .pl_clk(pl_clk), .pl_rst(pl_rst),
      .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(d2_rsp_write),
      .rsp_rdata(d2_rsp_rdata), .rsp_resp(d2_rsp_resp), .rsp_latency(d2_rsp_latency),
      .err_count(d2_err_count),
      .m_axi_awaddr(d2_awaddr), .m_axi_awvalid(d2_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(d2_wdata), .m_axi_wstrb(d2_wstrb), .m_axi_wvalid(d2_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(d2_bready), .m_axi_araddr(d2_araddr), .m_axi_arvalid(d2_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(d2_rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      rsp_ready = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
      chk({tag, "_vr"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, rsp_valid}), 64'(0));
      chk({tag, "_addr"}, 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
      chk({tag, "_wdata"}, 64'({m_axi_wdata, m_axi_wstrb}), 64'(0));
      chk({tag, "_rsp"}, 64'({rsp_write, rsp_rdata, rsp_resp, rsp_latency}), 64'(0));
      chk({tag, "_err"}, 64'(err_count), 64'(0));
      chk({tag, "_err2"}, 64'(d2_err_count), 64'(0));
   endtask

   // One transaction from the host side with a slave that follows the given delays.
   // The model tracks which AXI handshakes are still owed and predicts every cycle's valids.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int ar_dly, input int b_dly, input int r_dly,
                          input logic [1:0] resp, input logic [31:0] rdat,
                          input int rsp_dly, input int rst_cyc);
      bit aw_p, w_p, ar_p, b_p, r_p, s_p, fin;
      bit hs_aw, hs_w, hs_ar, hs_b, hs_r;
      int b_st, r_st, s_st, k;
      logic [31:0] exp_rdata;
      aw_p = wr; w_p = wr; ar_p = !wr; b_p = 0; r_p = 0; s_p = 0; fin = 0;
      b_st = 0; r_st = 0; s_st = 0; k = 0;
      exp_rdata = wr ? 32'd0 : rdat;
      @(negedge pl_clk);
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdat; cmd_wstrb = strb;
      for (int n = 1; n <= 200 && !fin; n++) begin
         @(negedge pl_clk);
         cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom;
         cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
         chk("hs_outs", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready, rsp_valid}),
             64'({1'b0, aw_p, w_p, b_p, ar_p, r_p, s_p}));
         if (aw_p) chk("awaddr", 64'(m_axi_awaddr), 64'(addr & ~32'd3));
         if (w_p)  chk("wdata", 64'({m_axi_wdata, m_axi_wstrb}), 64'({wdat, strb}));
         if (ar_p) chk("araddr", 64'(m_axi_araddr), 64'(addr & ~32'd3));
         if (s_p) begin
            chk("rsp_write", 64'(rsp_write), 64'(wr));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(resp));
            chk("rsp_latency", 64'(rsp_latency), 64'(k));
            chk("err_count", 64'(err_count), 64'(err_model));
            chk("lat_sat4", 64'(d2_rsp_latency), 64'((k > 15) ? 15 : k));
            chk("err_sat2", 64'(d2_err_count), 64'((err_model > 3) ? 3 : err_model));
         end
         if (n == rst_cyc) begin
            pl_rst = 1'b1; cmd_valid = 1'b0; slave_idle();
            @(negedge pl_clk);
            chk_reset("midrst");
            pl_rst = 1'b0; err_model = 0;
            return;
         end
         m_axi_awready = (n >= 1 + aw_dly);
         m_axi_wready  = (n >= 1 + w_dly);
         m_axi_arready = ar_p && (n >= 1 + ar_dly);
         m_axi_bvalid  = b_p && (n >= b_st + b_dly);
         m_axi_bresp   = m_axi_bvalid ? resp : 2'($urandom);
         m_axi_rvalid  = r_p && (n >= r_st + r_dly);
         m_axi_rresp   = m_axi_rvalid ? resp : 2'($urandom);
         m_axi_rdata   = m_axi_rvalid ? rdat : $urandom;
         rsp_ready     = s_p && (n >= s_st + rsp_dly);
         hs_aw = aw_p && m_axi_awready;
         hs_w  = w_p && m_axi_wready;
         hs_ar = ar_p && m_axi_arready;
         hs_b  = b_p && m_axi_bvalid;
         hs_r  = r_p && m_axi_rvalid;
         if (wr && (aw_p || w_p) && (!aw_p || hs_aw) && (!w_p || hs_w)) begin
            b_p = 1; b_st = n + 1;
         end
         if (hs_aw) aw_p = 0;
         if (hs_w)  w_p = 0;
         if (hs_ar) begin ar_p = 0; r_p = 1; r_st = n + 1; end
         if (hs_b || hs_r) begin
            b_p = 0; r_p = 0; s_p = 1; s_st = n + 1; k = n;
            if (resp != 2'b00 && err_model < 65535) err_model++;
         end else if (s_p && rsp_ready) begin
            fin = 1;
         end
      end
      chk("txn_done", 64'(fin), 64'(1));
      @(negedge pl_clk);
      cmd_valid = 1'b0; slave_idle();
      chk("cmd_ready_after", 64'(cmd_ready), 64'(1));
      chk("rsp_valid_after", 64'(rsp_valid), 64'(0));
   endtask

   initial begin
      pl_rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      slave_idle();
      repeat (3) @(negedge pl_clk);
      chk_reset("reset");
      pl_rst = 1'b0;

      // always-ready write, bvalid one cycle after AW/W: latency 2
      run_txn(1, 32'h6, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);
      // read with arready delayed 3 cycles, SLVERR
      run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 3, 0, 0, 2'b10, 32'hDEAD_BEEF, 0, 0);
      // W completes 5 cycles before AW
      run_txn(1, 32'h1234_5677, 32'h0BAD_F00D, 4'h5, 5, 0, 0, 1, 0, 2'b00, 32'h0, 0, 0);
      // response held off for 10 cycles with junk commands offered
      run_txn(0, 32'h8000_0003, 32'h0, 4'h0, 0, 0, 1, 0, 2, 2'b01, 32'h1357_9BDF, 10, 0);
      // bvalid withheld 20 cycles: the 4-bit latency counter saturates at 15
      run_txn(1, 32'h40, 32'hFFFF_FFFF, 4'h3, 0, 0, 0, 20, 0, 2'b11, 32'h0, 1, 0);
      // reset while waiting in WR_RESP
      run_txn(1, 32'h44, 32'h2222_3333, 4'hC, 0, 0, 0, 10, 0, 2'b00, 32'h0, 0, 3);

      for (int t = 0; t < 40; t++) begin
         automatic bit wr = 1'($urandom);
         automatic int bd = ($urandom_range(0, 7) == 0) ? 18 : $urandom_range(0, 3);
         run_txn(wr, $urandom, $urandom, 4'($urandom), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4), bd, $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_port.md
Name: axi_lite_master_port

Overview:
- Single-outstanding AXI4-Lite initiator for PL logic. It turns a simple command/response handshake into AXI-Lite write or read transactions toward a register slave, e.g. the team's control/status register block or a peer PL peripheral.
- Also reports per-transaction latency and a running count of error responses, for bring-up and diagnostics.

Parameters:
- ADDR_W, 32, AXI address width.
- LAT_W, 16, width of the saturating latency counter.
- ERR_W, 16, width of the saturating error counter.

Ports:
- pl_clk  in  1  sole clock; all ports are synchronous to it.
- pl_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- rsp_latency  out  LAT_W  cycles from command accept to AXI response handshake.
- err_count  out  ERR_W  count of non-OKAY responses.
- m_axi_awaddr  out  ADDR_W
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  ADDR_W
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- One clock, pl_clk; reset pl_rst is synchronous and active-high.
- All outputs are registered.

Reset:
- State = IDLE, cmd_ready = 1.
- All AXI valid/ready outputs = 0; addr/data/strb = 0.
- rsp_* = 0, err_count = 0.
- Reset mid-transaction abandons the transaction on the next edge with no response issued. The slave must be reset together with this block.

IDLE:
- On the accept edge (cmd_valid & cmd_ready): latch addr with bits [1:0] forced to 0; latch wdata/wstrb; clear the latency counter; cmd_ready = 0.
- cmd_write = 1 → WR, with awvalid = wvalid = 1 from the next cycle.
- cmd_write = 0 → RD, with arvalid = 1 from the next cycle.

WR:
- awvalid is held until it is sampled with awready. wvalid is held independently until it is sampled with wready.
- The AW and W handshakes may complete in either order or on the same edge. Neither valid is dropped before its own handshake.
- Address and data stay stable while valid is high.
- On the edge where both handshakes are complete → WR_RESP with bready = 1.

WR_RESP:
- On bvalid & bready: capture bresp into rsp_resp, set rsp_rdata = 0, bready = 0 → RSP.

RD:
- arvalid is held until arready → RD_DATA with rready = 1.

RD_DATA:
- On rvalid & rready: capture rdata and rresp, rready = 0 → RSP.

RSP:
- rsp_valid = 1 and all rsp_* fields stay stable until rsp_valid & rsp_ready → IDLE with cmd_ready = 1 on the next cycle.
- No new command is accepted while in RSP.

Latency:
- With accept on edge T and response handshake on edge T+k, rsp_latency = k.
- Saturates at 2^LAT_W-1 and does not wrap.

Error counter:
- Increments by 1 on each B/R handshake whose resp != 2'b00.
- Saturates at all-ones.
- Cleared only by reset.

AXI output defaults:
- awprot/arprot are not exported; the system ties them to 0.
- No combinational path exists from any AXI input to any AXI output.

Throughput:
- At most one outstanding transaction at a time.
- Back-to-back commands with an always-ready slave and rsp_ready held high achieve one transaction per 4 cycles (write).

Test Plan:
- Write, slave with awready = wready = 1 always and bvalid = 1 with bresp = 00 one cycle after the handshake; cmd addr = 0x6, wdata = 0xA5A5_0001, wstrb = 0xF → awaddr = 0x4, wdata/wstrb as given, rsp_resp = 00, rsp_rdata = 0, rsp_latency = 2, err_count = 0.
- Read of addr 0x10, slave with arready delayed 3 cycles and rdata = 0xDEADBEEF, rresp = 10 → arvalid held high for 4 cycles, rsp_rdata = 0xDEADBEEF, rsp_resp = 10, err_count = 1.
- Write with wready asserted 5 cycles before awready → wvalid drops after its handshake, awvalid stays high, bready rises only after the AW handshake, exactly one response is issued.
- rsp_ready held low for 10 cycles → rsp fields stable, cmd_ready = 0 throughout, cmd_valid ignored; after rsp_ready, cmd_ready = 1 on the next cycle.
- pl_rst asserted while in WR_RESP → all AXI valid/ready outputs and rsp_valid = 0 on the next edge, cmd_ready = 1, err_count = 0.
- With LAT_W = 4 and bvalid withheld for 20 cycles → rsp_latency = 15.
